// File: rtl/cpu_control_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// ALU operation encodings, instruction field positions and decode helpers.
package cpu_control_pkg;

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StRead  = 3'd1,
    StExec  = 3'd2,
    StMem   = 3'd3,
    StWb    = 3'd4
  } state_e;

  localparam logic [7:0] OpLoadi = 8'h00;
  localparam logic [7:0] OpMov   = 8'h01;
  localparam logic [7:0] OpAdd   = 8'h02;
  localparam logic [7:0] OpSub   = 8'h03;
  localparam logic [7:0] OpAnd   = 8'h04;
  localparam logic [7:0] OpOr    = 8'h05;
  localparam logic [7:0] OpJ     = 8'h06;
  localparam logic [7:0] OpBeq   = 8'h07;
  localparam logic [7:0] OpLwd   = 8'h08;
  localparam logic [7:0] OpSwd   = 8'h09;

  localparam logic [2:0] AluFwd = 3'd0;
  localparam logic [2:0] AluAdd = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;

  localparam int unsigned OpcodeLsb = 24;
  localparam int unsigned OffsetLsb = 16;
  localparam int unsigned DestLsb   = 16;
  localparam int unsigned Src1Lsb   = 8;
  localparam int unsigned Src2Lsb   = 0;
  localparam int unsigned ImmLsb    = 0;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       imm_sel;
    logic       neg_sel;
  } alu_ctrl_t;

  function automatic logic [7:0] f_opcode(input logic [31:0] ir);
    return ir[OpcodeLsb +: 8];
  endfunction

  function automatic logic [7:0] f_offset(input logic [31:0] ir);
    return ir[OffsetLsb +: 8];
  endfunction

  function automatic logic [2:0] f_dest(input logic [31:0] ir);
    return ir[DestLsb +: 3];
  endfunction

  function automatic logic [2:0] f_src1(input logic [31:0] ir);
    return ir[Src1Lsb +: 3];
  endfunction

  function automatic logic [2:0] f_src2(input logic [31:0] ir);
    return ir[Src2Lsb +: 3];
  endfunction

  function automatic logic [7:0] f_imm(input logic [31:0] ir);
    return ir[ImmLsb +: 8];
  endfunction

  // ALU setup per opcode; sub and beq both compute src1 - src2.
  function automatic alu_ctrl_t alu_decode(input logic [7:0] op);
    alu_ctrl_t ctrl;
    ctrl = '{alu_op: AluFwd, imm_sel: 1'b0, neg_sel: 1'b0};
    case (op)
      OpLoadi: ctrl.imm_sel = 1'b1;
      OpAdd:   ctrl.alu_op  = AluAdd;
      OpSub:   begin ctrl.alu_op = AluAdd; ctrl.neg_sel = 1'b1; end
      OpAnd:   ctrl.alu_op  = AluAnd;
      OpOr:    ctrl.alu_op  = AluOr;
      OpBeq:   begin ctrl.alu_op = AluAdd; ctrl.neg_sel = 1'b1; end
      default: ;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Bus between the control unit and the datapath it steers (instruction
// source, register file, ALU and data memory).
interface cpu_control_if;

  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        ALU_ZERO;
  logic        MEM_BUSY;
  logic [31:0] PC;
  logic [2:0]  OUT1ADDRESS;
  logic [2:0]  OUT2ADDRESS;
  logic [2:0]  INADDRESS;
  logic        WRITE;
  logic [7:0]  IMMEDIATE;
  logic [2:0]  ALUOP;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic        WB_SEL;
  logic        ILLEGAL;

  modport master (
    input  INSTRUCTION, INSTR_VALID, ALU_ZERO, MEM_BUSY,
    output PC, OUT1ADDRESS, OUT2ADDRESS, INADDRESS, WRITE, IMMEDIATE, ALUOP,
           IMM_SEL, NEG_SEL, MEM_READ, MEM_WRITE, WB_SEL, ILLEGAL
  );

  modport slave (
    output INSTRUCTION, INSTR_VALID, ALU_ZERO, MEM_BUSY,
    input  PC, OUT1ADDRESS, OUT2ADDRESS, INADDRESS, WRITE, IMMEDIATE, ALUOP,
           IMM_SEL, NEG_SEL, MEM_READ, MEM_WRITE, WB_SEL, ILLEGAL
  );

endinterface

// File: rtl/cpu_control_pc_next.sv
// Next program counter: sequential PC+4 or branch target PC+4+(offset*4).
module cpu_control_pc_next (
  input  logic [31:0] pc_i,
  input  logic [7:0]  offset_i,
  input  logic        taken_i,
  output logic [31:0] pc_next_o
);

  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4  = pc_i + 32'd4;
  // Offset counts signed words; wrap-around is intentional.
  assign target    = pc_plus4 + {{22{offset_i[7]}}, offset_i, 2'b00};
  assign pc_next_o = taken_i ? target : pc_plus4;

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle control unit: fetch, register read, execute, memory, write-back.
// All datapath controls are Moore outputs of the state register and IR.
module cpu_control
  import cpu_control_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  cpu_control_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic        illegal_q, illegal_d;
  logic        pc_adv;
  logic        taken;
  logic [31:0] pc_next;
  logic [7:0]  opcode;
  alu_ctrl_t   alu_ctrl;
  logic        unused_ir;

  assign opcode    = f_opcode(ir_q);
  assign alu_ctrl  = alu_decode(opcode);
  assign unused_ir = ^ir_q[15:11];

  cpu_control_pc_next u_pc_next (
    .pc_i      (pc_q),
    .offset_i  (f_offset(ir_q)),
    .taken_i   (taken),
    .pc_next_o (pc_next)
  );

  // State, IR, PC and sticky illegal flag; reset wins over every state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StFetch;
      ir_q      <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state; pc_adv marks the last cycle of an instruction.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_adv    = 1'b0;
    taken     = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (bus.INSTR_VALID) begin
          ir_d    = bus.INSTRUCTION;
          state_d = StRead;
        end
      end
      StRead: state_d = StExec;
      StExec: begin
        case (opcode)
          OpLoadi, OpMov, OpAdd, OpSub, OpAnd, OpOr: state_d = StWb;
          OpLwd, OpSwd: state_d = StMem;
          OpJ: begin
            taken   = 1'b1;
            pc_adv  = 1'b1;
            state_d = StFetch;
          end
          OpBeq: begin
            taken   = bus.ALU_ZERO;
            pc_adv  = 1'b1;
            state_d = StFetch;
          end
          default: begin
            illegal_d = 1'b1;
            pc_adv    = 1'b1;
            state_d   = StFetch;
          end
        endcase
      end
      StMem: begin
        if (!bus.MEM_BUSY) begin
          if (opcode == OpLwd) begin
            state_d = StWb;
          end else begin
            pc_adv  = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StWb: begin
        pc_adv  = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    pc_d = pc_adv ? pc_next : pc_q;
  end

  // Datapath controls decoded from registered state and IR only.
  always_comb begin
    bus.PC          = pc_q;
    bus.ILLEGAL     = illegal_q;
    bus.OUT1ADDRESS = '0;
    bus.OUT2ADDRESS = '0;
    bus.IMMEDIATE   = '0;
    bus.INADDRESS   = '0;
    bus.WRITE       = 1'b0;
    bus.WB_SEL      = 1'b0;
    bus.ALUOP       = AluFwd;
    bus.IMM_SEL     = 1'b0;
    bus.NEG_SEL     = 1'b0;
    bus.MEM_READ    = 1'b0;
    bus.MEM_WRITE   = 1'b0;
    if (state_q != StFetch) begin
      bus.OUT1ADDRESS = f_src1(ir_q);
      bus.OUT2ADDRESS = f_src2(ir_q);
      bus.IMMEDIATE   = f_imm(ir_q);
    end
    // ALU setup held through MEM/WB so the write-back value stays stable.
    if (state_q == StExec || state_q == StMem || state_q == StWb) begin
      bus.ALUOP   = alu_ctrl.alu_op;
      bus.IMM_SEL = alu_ctrl.imm_sel;
      bus.NEG_SEL = alu_ctrl.neg_sel;
    end
    if (state_q == StMem) begin
      bus.MEM_READ  = (opcode == OpLwd);
      bus.MEM_WRITE = (opcode == OpSwd);
    end
    if (state_q == StWb) begin
      bus.WRITE     = 1'b1;
      bus.INADDRESS = f_dest(ir_q);
      bus.WB_SEL    = (opcode == OpLwd);
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed instructions followed by a
// random instruction stream, compared against an instruction-level model.
module tb_cpu_control;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  logic [31:0] m_pc;
  logic        m_illegal;

  cpu_control_if bus ();

  cpu_control dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] quiet_bits();
    return {bus.WRITE, bus.MEM_READ, bus.MEM_WRITE, bus.WB_SEL, bus.INADDRESS,
            bus.OUT1ADDRESS, bus.OUT2ADDRESS, bus.IMM_SEL, bus.NEG_SEL};
  endfunction

  // Instruction-level expectations taken from the ISA cycle table.
  task automatic model(input logic [31:0] ir, input int busy, input bit zero,
                       output int cycles, output int writes, output int rds, output int wrs,
                       output logic [4:0] alu, output bit taken, output bit illegal);
    int n;
    n       = busy + 1;
    writes  = 0;
    rds     = 0;
    wrs     = 0;
    alu     = 5'b000_0_0;
    taken   = 1'b0;
    illegal = 1'b0;
    cycles  = 4;
    case (ir[31:24])
      8'h00: begin writes = 1; alu = 5'b000_1_0; end
      8'h01: writes = 1;
      8'h02: begin writes = 1; alu = 5'b001_0_0; end
      8'h03: begin writes = 1; alu = 5'b001_0_1; end
      8'h04: begin writes = 1; alu = 5'b010_0_0; end
      8'h05: begin writes = 1; alu = 5'b011_0_0; end
      8'h06: begin cycles = 3; taken = 1'b1; end
      8'h07: begin cycles = 3; taken = zero; alu = 5'b001_0_1; end
      8'h08: begin cycles = 4 + n; writes = 1; rds = n; end
      8'h09: begin cycles = 3 + n; wrs = n; end
      default: begin cycles = 3; illegal = 1'b1; end
    endcase
  endtask

  // Issue one instruction from FETCH and watch it until two stall cycles after it ends.
  task automatic run_instr(input logic [31:0] ir, input int busy, input bit zero,
                           input string name);
    int cycles, writes, rds, wrs, wcnt, wcycle, rdcnt, wrcnt, memk;
    logic [4:0]  alu, wctl;
    logic [2:0]  waddr;
    logic        wbsel;
    bit          taken, illegal;
    logic [31:0] exp_pc, off, rnd;
    model(ir, busy, zero, cycles, writes, rds, wrs, alu, taken, illegal);
    off    = {{22{ir[23]}}, ir[23:16], 2'b00};
    exp_pc = m_pc + 32'd4 + (taken ? off : 32'd0);
    if (illegal) m_illegal = 1'b1;
    wcnt = 0; wcycle = 0; rdcnt = 0; wrcnt = 0; memk = 0;
    waddr = '0; wbsel = 1'b0; wctl = '0;
    bus.ALU_ZERO = zero;
    for (int c = 1; c <= cycles + 2; c++) begin
      rnd = $urandom;
      bus.INSTR_VALID = (c == 1);
      bus.INSTRUCTION = (c == 1) ? ir : rnd;
      if (bus.WRITE) begin
        wcnt++;
        wcycle = c;
        waddr  = bus.INADDRESS;
        wbsel  = bus.WB_SEL;
        wctl   = {bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL};
      end
      if (bus.MEM_READ) rdcnt++;
      if (bus.MEM_WRITE) wrcnt++;
      if (bus.MEM_READ || bus.MEM_WRITE) begin
        memk++;
        bus.MEM_BUSY = (memk <= busy);
      end else begin
        bus.MEM_BUSY = rnd[31];
      end
      if (c == 2) begin
        check({name, "_rd1"}, 32'(bus.OUT1ADDRESS), 32'(ir[10:8]));
        check({name, "_rd2"}, 32'(bus.OUT2ADDRESS), 32'(ir[2:0]));
      end
      if (c == 3) begin
        check({name, "_alu"}, 32'({bus.ALUOP, bus.IMM_SEL, bus.NEG_SEL}), 32'(alu));
        check({name, "_imm"}, 32'(bus.IMMEDIATE), 32'(ir[7:0]));
      end
      if (c == cycles) check({name, "_pc_hold"}, bus.PC, m_pc);
      if (c == cycles + 1) begin
        check({name, "_pc_next"}, bus.PC, exp_pc);
        check({name, "_illegal"}, 32'(bus.ILLEGAL), 32'(m_illegal));
        check({name, "_quiet"}, 32'(quiet_bits()), 32'd0);
      end
      if (c == cycles + 2) check({name, "_pc_stall"}, bus.PC, exp_pc);
      @(negedge clk);
    end
    check({name, "_writes"}, 32'(wcnt), 32'(writes));
    check({name, "_memrd"}, 32'(rdcnt), 32'(rds));
    check({name, "_memwr"}, 32'(wrcnt), 32'(wrs));
    if (writes == 1) begin
      check({name, "_wb_cycle"}, 32'(wcycle), 32'(cycles));
      check({name, "_wb_addr"}, 32'(waddr), 32'(ir[18:16]));
      check({name, "_wb_sel"}, 32'(wbsel), 32'(ir[31:24] == 8'h08));
      check({name, "_wb_alu"}, 32'(wctl), 32'(alu));
    end
    m_pc = exp_pc;
  endtask

  initial begin
    logic [31:0] rw;
    logic [7:0]  op;
    int          r;
    rst             = 1'b1;
    bus.INSTRUCTION = '0;
    bus.INSTR_VALID = 1'b0;
    bus.ALU_ZERO    = 1'b0;
    bus.MEM_BUSY    = 1'b0;
    m_pc            = '0;
    m_illegal       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_pc", bus.PC, 32'd0);
    check("reset_illegal", 32'(bus.ILLEGAL), 32'd0);
    check("reset_outputs", 32'({quiet_bits(), bus.IMMEDIATE, bus.ALUOP}), 32'd0);
    rst = 1'b0;

    run_instr(32'h0003_002A, 0, 1'b0, "loadi");
    check("loadi_pc", bus.PC, 32'h4);
    run_instr(32'h0301_0205, 0, 1'b0, "sub");
    run_instr(32'h0102_0003, 0, 1'b0, "mov");
    run_instr(32'h0403_0107, 0, 1'b0, "and");
    run_instr(32'h07FE_0304, 0, 1'b1, "beq_t");
    check("beq_taken_pc", bus.PC, 32'h0C);
    run_instr(32'h0506_0201, 0, 1'b0, "or");
    run_instr(32'h07FE_0304, 0, 1'b0, "beq_nt");
    check("beq_not_taken_pc", bus.PC, 32'h14);
    run_instr(32'h0603_0000, 0, 1'b0, "j");
    run_instr(32'h0804_0006, 2, 1'b0, "lwd");
    run_instr(32'h0900_0305, 0, 1'b0, "swd");
    run_instr(32'hFF12_3456, 0, 1'b0, "bad_op");
    check("illegal_set", 32'(bus.ILLEGAL), 32'd1);

    for (int i = 0; i < 60; i++) begin
      rw = $urandom;
      r  = $urandom_range(0, 11);
      op = (r < 10) ? 8'(r) : 8'($urandom_range(10, 255));
      run_instr({op, rw[23:0]}, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
    end
    check("illegal_sticky", 32'(bus.ILLEGAL), 32'd1);

    // Reset during the WB cycle of an add.
    bus.INSTRUCTION = 32'h0205_0102;
    bus.INSTR_VALID = 1'b1;
    @(negedge clk);
    bus.INSTR_VALID = 1'b0;
    repeat (2) @(negedge clk);
    check("wb_before_reset", 32'(bus.WRITE), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_wb_write", 32'(bus.WRITE), 32'd0);
    check("reset_wb_pc", bus.PC, 32'd0);
    check("reset_wb_illegal", 32'(bus.ILLEGAL), 32'd0);
    check("reset_wb_quiet", 32'(quiet_bits()), 32'd0);
    m_pc      = '0;
    m_illegal = 1'b0;

    // Reset while a load is stuck in MEM.
    bus.INSTRUCTION = 32'h0802_0003;
    bus.INSTR_VALID = 1'b1;
    bus.MEM_BUSY    = 1'b1;
    @(negedge clk);
    bus.INSTR_VALID = 1'b0;
    repeat (3) @(negedge clk);
    check("mem_pending", 32'(bus.MEM_READ), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.MEM_BUSY = 1'b0;
    check("reset_mem_drop", 32'({bus.MEM_READ, bus.MEM_WRITE}), 32'd0);
    check("reset_mem_pc", bus.PC, 32'd0);

    run_instr(32'h0007_0011, 0, 1'b0, "after_reset");
    check("after_reset_pc", bus.PC, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
